// File: rtl/cache_mem_pkg.sv
// Types and helpers shared by the line-side memory responder and the data cache controller.
package cache_mem_pkg;

  localparam int LINE_WORDS_DEFAULT = 4;
  localparam int DATA_W_DEFAULT     = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } mem_state_e;

  // Word index of the first word of the line holding byte_addr, before any depth wrap.
  function automatic logic [63:0] line_base_index(input logic [63:0] byte_addr,
                                                  input logic [31:0] line_words);
    logic [63:0] mask;
    mask = ~({32'd0, line_words} - 64'd1);
    return (byte_addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/cache_line_mem_array.sv
// Single-port word RAM with write enable and a registered read port.
module cache_line_mem_array
  import cache_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Read returns the old word on a write cycle; the responder never reads and writes together.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_line_mem_responder.sv
// Line-side backing memory for the data cache: burst line fills and write-backs after a fixed latency.
module cache_line_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int ADDR_W      = 32,
  parameter int LINE_WORDS  = LINE_WORDS_DEFAULT,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              busy
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  mem_state_e        state;
  mem_state_e        next_state;
  logic [IDX_W-1:0]  base;
  logic              is_write;
  logic [BEAT_W-1:0] beat;
  logic [LAT_W-1:0]  lat_cnt;

  logic              last_beat;
  logic              req_fire;
  logic              rd_fire;
  logic              wr_fire;
  logic [IDX_W-1:0]  req_base;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign req_base  = IDX_W'(line_base_index(64'(req_addr), 32'(LINE_WORDS)));
  assign last_beat = (beat == LAST_BEAT);
  assign req_fire  = (state == IDLE) && req_valid;
  assign rd_fire   = (state == RBURST) && rd_ready;
  assign wr_fire   = (state == WBURST) && wr_valid;
  assign busy      = (state != IDLE);
  assign rd_data   = (state == RBURST) ? ram_rdata : '0;

  // The RAM read is registered, so the address runs one beat ahead when a read beat is taken;
  // during WAIT it sits on the base so the first word is ready as RBURST begins.
  assign ram_addr = base + IDX_W'(beat) + (rd_fire ? IDX_W'(1) : IDX_W'(0));

  cache_line_mem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (wr_fire),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    wr_ready   = 1'b0;
    wr_done    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) next_state = is_write ? WBURST : RBURST;
      end
      RBURST: begin
        rd_valid = 1'b1;
        rd_last  = last_beat;
        if (rd_ready && last_beat) next_state = IDLE;
      end
      WBURST: begin
        wr_ready = 1'b1;
        if (wr_valid && last_beat) next_state = DONE;
      end
      DONE: begin
        wr_done    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat counter wraps to zero after the last beat, leaving it ready for the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      is_write <= 1'b0;
      beat     <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= next_state;
      if (req_fire) begin
        base     <= req_base;
        is_write <= req_write;
        beat     <= '0;
        lat_cnt  <= LAT_LOAD;
      end
      if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (rd_fire || wr_fire) begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

endmodule
